// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_pkg : FSM state encoding and instruction width for fetch_unit  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package fetch_pkg;

  localparam int c_INSTR_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_EXEC  = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_unit_if : control, memory and core handshake bundle            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface fetch_unit_if
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 8
) ();

  logic                 start;
  logic [ADDR_W-1:0]    start_addr;
  logic [ADDR_W-1:0]    end_addr;
  logic                 mem_req;
  logic [ADDR_W-1:0]    mem_addr;
  logic [c_INSTR_W-1:0] mem_rdata;
  logic                 mem_rvalid;
  logic [c_INSTR_W-1:0] instruction;
  logic                 run;
  logic                 done;
  logic [ADDR_W-1:0]    pc;
  logic                 busy;
  logic                 halted;
  logic                 mem_err;

  modport master (
    input  start, start_addr, end_addr, mem_rdata, mem_rvalid, done,
    output mem_req, mem_addr, instruction, run, pc, busy, halted, mem_err
  );

  modport slave (
    output start, start_addr, end_addr, mem_rdata, mem_rvalid, done,
    input  mem_req, mem_addr, instruction, run, pc, busy, halted, mem_err
  );

endinterface
`default_nettype wire

// File: rtl/program_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | program_counter : loadable address counter, wraps at 2^ADDR_W        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module program_counter #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_addr,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_pc
);

  logic [ADDR_W-1:0] r_pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc <= '0;
    end else if (i_load) begin
      r_pc <= i_load_addr;
    end else if (i_inc) begin
      r_pc <= r_pc + ADDR_W'(1);
    end
  end

  assign o_pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_unit : fetches instructions start..end and hands each to core  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);

  // WAIT edges are counted from 0, so the last permitted edge sees MEM_TIMEOUT-1.
  localparam logic [7:0] c_TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t               r_state;
  state_t               w_next_state;
  logic [7:0]           r_tmo_cnt;
  logic [7:0]           w_tmo_cnt_next;
  logic                 w_load;
  logic                 w_inc;
  logic                 w_capture;
  logic                 w_set_err;
  logic                 w_clr_err;
  logic [ADDR_W-1:0]    w_pc;
  logic [ADDR_W-1:0]    r_end_addr;
  logic [c_INSTR_W-1:0] r_instr;
  logic                 r_mem_req;
  logic                 r_run;
  logic                 r_busy;
  logic                 r_halted;
  logic                 r_mem_err;

  program_counter #(
    .ADDR_W (ADDR_W)
  ) u_pc (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_load),
    .i_load_addr (bus.start_addr),
    .i_inc       (w_inc),
    .o_pc        (w_pc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_tmo_cnt <= '0;
    end else begin
      r_state   <= w_next_state;
      r_tmo_cnt <= w_tmo_cnt_next;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_tmo_cnt_next = r_tmo_cnt;
    w_load         = 1'b0;
    w_inc          = 1'b0;
    w_capture      = 1'b0;
    w_set_err      = 1'b0;
    w_clr_err      = 1'b0;
    case (r_state)
      ST_IDLE, ST_HALT: begin
        if (bus.start) begin
          w_load       = 1'b1;
          w_clr_err    = 1'b1;
          w_next_state = ST_FETCH;
        end
      end
      ST_FETCH: begin
        w_tmo_cnt_next = '0;
        w_next_state   = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.mem_rvalid) begin
          w_capture    = 1'b1;
          w_next_state = ST_EXEC;
        end else if (r_tmo_cnt == c_TMO_LAST) begin
          w_set_err    = 1'b1;
          w_next_state = ST_HALT;
        end else begin
          w_tmo_cnt_next = r_tmo_cnt + 8'd1;
        end
      end
      ST_EXEC: begin
        if (bus.done) begin
          if (w_pc == r_end_addr) begin
            w_next_state = ST_HALT;
          end else begin
            w_inc        = 1'b1;
            w_next_state = ST_FETCH;
          end
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with r_state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_end_addr <= '0;
      r_instr    <= '0;
      r_mem_req  <= 1'b0;
      r_run      <= 1'b0;
      r_busy     <= 1'b0;
      r_halted   <= 1'b0;
      r_mem_err  <= 1'b0;
    end else begin
      if (w_load) begin
        r_end_addr <= bus.end_addr;
      end
      if (w_capture) begin
        r_instr <= bus.mem_rdata;
      end
      if (w_set_err) begin
        r_mem_err <= 1'b1;
      end else if (w_clr_err) begin
        r_mem_err <= 1'b0;
      end
      r_mem_req <= (w_next_state == ST_FETCH);
      r_run     <= (w_next_state == ST_EXEC);
      r_busy    <= (w_next_state == ST_FETCH) || (w_next_state == ST_WAIT) ||
                   (w_next_state == ST_EXEC);
      r_halted  <= (w_next_state == ST_HALT);
    end
  end

  assign bus.mem_req     = r_mem_req;
  assign bus.mem_addr    = w_pc;
  assign bus.pc          = w_pc;
  assign bus.instruction = r_instr;
  assign bus.run         = r_run;
  assign bus.busy        = r_busy;
  assign bus.halted      = r_halted;
  assign bus.mem_err     = r_mem_err;

endmodule
`default_nettype wire
